// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP           = 32'd4;
  localparam int unsigned BUF_DEPTH_DEFAULT = 2;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; used for the prefetch buffer and the tag queue.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;
  logic             do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; flush empties without touching storage.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited requests, in-order tagging, prefetch buffer, branch drain.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  state_t            state_q;
  state_t            state_d;
  logic [31:0]       fetch_pc_q;
  logic [31:0]       fetch_pc_d;
  logic [CNT_W-1:0]  discard_q;
  logic [CNT_W-1:0]  discard_d;
  logic              err_unexp;

  logic [CNT_W-1:0]  buf_count;
  logic [CNT_W-1:0]  tag_count;
  logic [CNT_W-1:0]  outstanding;
  entry_t            buf_head;
  entry_t            buf_wdata;
  logic [31:0]       tag_head;
  logic              pop_req;
  logic              grant;
  logic              rsp_ok;
  logic              push;
  logic              buf_pop;
  logic              tag_push;
  logic [SUM_W-1:0]  credit_used;

  // In RUN every in-flight request has a tag; in DRAIN every in-flight request is to be discarded.
  assign outstanding = tag_count + discard_q;
  assign buf_wdata   = '{pc: tag_head, instr: imem_rdata};

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    discard_d   = discard_q;

    instr_valid = !reset && (buf_count != '0);
    instr_out   = instr_valid ? buf_head.instr : '0;
    pc_out      = instr_valid ? buf_head.pc : '0;
    imem_addr   = reset ? RESET_PC : fetch_pc_q;

    pop_req     = instr_valid && !stall;
    credit_used = SUM_W'(outstanding) + SUM_W'(buf_count) - SUM_W'(pop_req);
    imem_req    = !reset && (state_q == RUN) && (credit_used < SUM_W'(BUF_DEPTH));
    grant       = imem_req && imem_gnt;
    rsp_ok      = imem_rvalid && (outstanding != '0);
    push        = rsp_ok && (state_q == RUN) && !branch_taken;
    tag_push    = grant && !branch_taken;
    buf_pop     = pop_req && !branch_taken;

    case (state_q)
      RUN: begin
        if (branch_taken) begin
          discard_d = outstanding - CNT_W'(rsp_ok) + CNT_W'(grant);
          state_d   = (discard_d != '0) ? DRAIN : RUN;
        end
      end
      DRAIN: begin
        discard_d = discard_q - CNT_W'(rsp_ok);
        if (!branch_taken && (discard_d == '0)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (branch_taken)  fetch_pc_d = {branch_target[31:2], 2'b00};
    else if (grant)    fetch_pc_d = fetch_pc_q + PC_STEP;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
      err_unexp  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      err_unexp  <= err_unexp | (imem_rvalid && (outstanding == '0));
    end
  end

  // Prefetch buffer of {pc, instr}.
  fetch_fifo #(.WIDTH(ENTRY_W), .DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (buf_pop),
    .flush (branch_taken),
    .wdata (buf_wdata),
    .head  (buf_head),
    .count (buf_count)
  );

  // Address tags of requests still awaiting their response.
  fetch_fifo #(.WIDTH(32), .DEPTH(BUF_DEPTH)) u_tag (
    .clk   (clk),
    .reset (reset),
    .push  (tag_push),
    .pop   (push),
    .flush (branch_taken),
    .wdata (imem_addr),
    .head  (tag_head),
    .count (tag_count)
  );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0, is the PC loaded on reset.
REQ-002 Parameter BUF_DEPTH, default 2, is the prefetch buffer depth and the outstanding-request credit limit.
REQ-003 CLK  in  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 RESET  in  1  is synchronous and active-high.
REQ-005 IMEM_REQ  out  1  is the instruction memory request.
REQ-006 IMEM_ADDR  out  32  is the request address, word aligned.
REQ-007 IMEM_GNT  in  1  means memory accepts the request this cycle.
REQ-008 IMEM_RVALID  in  1  means a response is present; responses SHALL arrive in order, at least 1 cycle after grant.
REQ-009 IMEM_RDATA  in  32  is the response instruction word.
REQ-010 STALL  in  1  is the hazard hold; the output is not consumed.
REQ-011 BRANCH_TAKEN  in  1  is the redirect request.
REQ-012 BRANCH_TARGET  in  32  is the redirect PC.
REQ-013 INSTR_OUT  out  32  is the head instruction, feeding the IF/ID register.
REQ-014 PC_OUT  out  32  is the PC of INSTR_OUT.
REQ-015 INSTR_VALID  out  1  means INSTR_OUT/PC_OUT are valid.

Function
REQ-016 fetch_pc SHALL drive IMEM_ADDR and SHALL advance by 4 (mod 2^32, wrapping) on each cycle where IMEM_REQ and IMEM_GNT are both high.
REQ-017 IMEM_REQ SHALL be high only in state RUN with credits available: outstanding + buf_count - pop < BUF_DEPTH, where pop = INSTR_VALID & !STALL.
REQ-018 IMEM_REQ and IMEM_ADDR SHALL remain stable while IMEM_GNT is low.
REQ-019 Each accepted response in RUN SHALL push {pc, IMEM_RDATA} into the buffer; the pc tag is the address of that request, taken from an in-order tag queue.
REQ-020 INSTR_VALID SHALL be high whenever the buffer is non-empty; INSTR_OUT/PC_OUT SHALL be the buffer head, or 0 when empty.
REQ-021 Pop SHALL occur when INSTR_VALID & !STALL; a simultaneous push and pop on a full buffer SHALL be legal and lossless.
REQ-022 Latency: a grant at cycle T with response at T+1 SHALL give INSTR_VALID at T+2; with 1-cycle memory and no stall, throughput SHALL be 1 instruction per cycle.
REQ-023 FSM states RUN and DRAIN; reset enters RUN.
REQ-024 On BRANCH_TAKEN the block SHALL, regardless of STALL:
- flush the buffer;
- set fetch_pc = {BRANCH_TARGET[31:2], 2'b00};
- suppress pop that cycle;
- set discard = outstanding - IMEM_RVALID, where outstanding excludes any grant in the same cycle, which is also counted toward discard;
- go to DRAIN if discard > 0, else RUN.
REQ-025 Branch priority: a response arriving in the BRANCH_TAKEN cycle SHALL be dropped; a grant in that cycle SHALL be counted for discard.
REQ-026 In DRAIN, IMEM_REQ SHALL be low; each IMEM_RVALID SHALL decrement discard without a push; at discard = 0 the FSM SHALL return to RUN.
REQ-027 BRANCH_TAKEN during DRAIN SHALL retarget fetch_pc, keep the remaining discard count minus any response that cycle, and stay in DRAIN.
REQ-028 IMEM_RVALID with outstanding = 0 SHALL be ignored and SHALL set sticky flag err_unexp, which is observable via hierarchy.

Reset
REQ-029 While RESET is high:
- IMEM_REQ = 0, INSTR_VALID = 0, INSTR_OUT = 0, PC_OUT = 0;
- fetch_pc = RESET_PC, IMEM_ADDR = RESET_PC;
- buffer, tag queue, outstanding, discard and err_unexp cleared;
- state RUN.
REQ-030 Reset asserted mid-operation SHALL drop all in-flight responses; responses arriving after reset deasserts with outstanding = 0 fall under REQ-028.
REQ-031 IMEM_REQ SHALL first assert in the first cycle after RESET deasserts.

Structure
REQ-032 Shared package fetch_pkg SHALL hold: RESET_PC default, PC_STEP = 4, BUF_DEPTH default, state enum {RUN, DRAIN}, and entry type {pc[31:0], instr[31:0]}.
REQ-033 A sub-module fetch_fifo (parameterised depth, push/pop/flush, count, head) SHALL be used for the buffer and instantiated again for the tag queue.

Verification
REQ-034 Reset release, memory always granting with 1-cycle latency, no stall -> grants at 0x0, 0x4, 0x8 on consecutive cycles; INSTR_VALID from cycle 2 with PC_OUT 0x0, 0x4, 0x8 back-to-back.
REQ-035 STALL held 4 cycles with buffer full -> IMEM_REQ low, INSTR_OUT/PC_OUT unchanged; on release, no instruction is lost or duplicated.
REQ-036 BRANCH_TAKEN to 0x103 with 2 outstanding -> DRAIN; 2 responses discarded; next grant at 0x100; first PC_OUT after the branch is 0x100.
REQ-037 BRANCH_TAKEN in the same cycle as IMEM_RVALID and STALL -> response dropped, buffer empty next cycle, fetch_pc = target.
REQ-038 fetch_pc = 0xFFFFFFFC granted -> next IMEM_ADDR = 0x0.
REQ-039 IMEM_GNT low for 3 cycles -> IMEM_ADDR stable; RESET asserted mid-DRAIN -> all outputs 0 and next request at RESET_PC.
